// File: rtl/bus_master.sv
// bus_master: sole initiator on the synth register bus. Queues host
// commands in a small FIFO and plays each one out as a timed bus cycle.
// Ports: BusClock, Reset (sync, active-low); Cmd* valid/ready command
// input; Rsp* valid/ready read response; BusAddress/BusData/BusReadWrite
// register bus; Busy = work queued or in flight.
module bus_master #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] IDLE_ADDR  = 16'hFFFF
) (
  input  logic        BusClock,
  input  logic        Reset,
  input  logic        CmdValid,
  output logic        CmdReady,
  input  logic        CmdWrite,
  input  logic [15:0] CmdAddr,
  input  logic [7:0]  CmdData,
  output logic        RspValid,
  input  logic        RspReady,
  output logic [7:0]  RspData,
  output logic [15:0] BusAddress,
  inout  wire  [7:0]  BusData,
  output logic        BusReadWrite,
  output logic        Busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   L_DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   L_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] P_ONE   = AW'(1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR      = 3'd1;
  localparam logic [2:0] S_RD_ADDR = 3'd2;
  localparam logic [2:0] S_RD_CAP  = 3'd3;
  localparam logic [2:0] S_GAP     = 3'd4;

  logic [24:0]   r_fifo [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [2:0]    r_state;
  logic [15:0]   r_bus_addr;
  logic          r_bus_rw;
  logic [7:0]    r_bus_dout;
  logic          r_rsp_valid;
  logic [7:0]    r_rsp_data;

  logic [24:0]   w_head;
  logic          w_push;
  logic          w_pop;
  logic          w_rsp_free;
  logic [2:0]    w_nxt;
  logic [15:0]   w_addr_n;
  logic          w_rw_n;
  logic [7:0]    w_dout_n;

  assign CmdReady   = (r_count < L_DEPTH);
  assign w_push     = CmdValid & CmdReady;
  assign w_head     = r_fifo[r_rptr];
  // A read may only launch if its result has somewhere to land.
  assign w_rsp_free = ~r_rsp_valid | RspReady;

  always_comb begin
    w_pop = 1'b0;
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          if (w_head[24]) begin
            w_pop = 1'b1;
            w_nxt = S_WR;
          end else if (w_rsp_free) begin
            w_pop = 1'b1;
            w_nxt = S_RD_ADDR;
          end
        end
      end
      S_WR:      w_nxt = S_GAP;
      S_RD_ADDR: w_nxt = S_RD_CAP;
      S_RD_CAP:  w_nxt = S_GAP;
      S_GAP:     w_nxt = S_IDLE;
      default:   w_nxt = S_IDLE;
    endcase
  end

  // Bus pins are registered: compute what the next state shows.
  always_comb begin
    w_addr_n = IDLE_ADDR;
    w_rw_n   = 1'b1;
    w_dout_n = 8'h00;
    unique case (w_nxt)
      S_WR: begin
        w_addr_n = w_head[23:8];
        w_dout_n = w_head[7:0];
      end
      S_RD_ADDR: begin
        w_addr_n = w_head[23:8];
        w_rw_n   = 1'b0;
      end
      S_RD_CAP: begin
        w_addr_n = r_bus_addr;
        w_rw_n   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge BusClock) begin
    if (w_push)
      r_fifo[r_wptr] <= {CmdWrite, CmdAddr, CmdData};
  end

  always_ff @(posedge BusClock) begin
    if (!Reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_state     <= S_IDLE;
      r_bus_addr  <= IDLE_ADDR;
      r_bus_rw    <= 1'b1;
      r_bus_dout  <= 8'h00;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'h00;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + P_ONE;
      if (w_pop)
        r_rptr <= r_rptr + P_ONE;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + L_ONE;
        2'b01:   r_count <= r_count - L_ONE;
        default: ;
      endcase
      r_state    <= w_nxt;
      r_bus_addr <= w_addr_n;
      r_bus_rw   <= w_rw_n;
      r_bus_dout <= w_dout_n;
      // Capture has priority over a same-cycle consume.
      if (r_state == S_RD_CAP) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= BusData;
      end else if (r_rsp_valid & RspReady) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign BusAddress   = r_bus_addr;
  assign BusReadWrite = r_bus_rw;
  assign BusData      = r_bus_rw ? r_bus_dout : 8'bz;
  assign RspValid     = r_rsp_valid;
  assign RspData      = r_rsp_data;
  assign Busy         = (r_count != '0) | (r_state != S_IDLE);

endmodule

// File: tb/tb_bus_master.sv
// tb_bus_master: directed bench for bus_master with a simple
// register-file slave on the bus.
module tb_bus_master;

  logic        BusClock = 1'b0;
  logic        Reset    = 1'b0;
  logic        CmdValid = 1'b0;
  logic        CmdWrite = 1'b0;
  logic [15:0] CmdAddr  = 16'h0;
  logic [7:0]  CmdData  = 8'h0;
  logic        RspReady = 1'b0;
  logic        CmdReady;
  logic        RspValid;
  logic [7:0]  RspData;
  logic [15:0] BusAddress;
  logic        BusReadWrite;
  logic        Busy;
  wire  [7:0]  BusData;

  int n_tot  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int base;
  int wn_snap;

  always #5 BusClock = ~BusClock;

  bus_master dut (
    .BusClock     (BusClock),
    .Reset        (Reset),
    .CmdValid     (CmdValid),
    .CmdReady     (CmdReady),
    .CmdWrite     (CmdWrite),
    .CmdAddr      (CmdAddr),
    .CmdData      (CmdData),
    .RspValid     (RspValid),
    .RspReady     (RspReady),
    .RspData      (RspData),
    .BusAddress   (BusAddress),
    .BusData      (BusData),
    .BusReadWrite (BusReadWrite),
    .Busy         (Busy)
  );

  // Slave: decodes 16'h00xx, registers read data at the end of the
  // address cycle and drives it while the bus stays in read.
  logic [7:0]  smem [256];
  logic [7:0]  s_q  = 8'h00;
  logic        s_oe = 1'b0;
  logic [15:0] wl_a [64];
  logic [7:0]  wl_d [64];
  int          wl_c [64];
  int          wn = 0;

  assign BusData = (s_oe && !BusReadWrite) ? s_q : 8'bz;

  always @(posedge BusClock) begin
    cyc <= cyc + 1;
    s_oe <= !BusReadWrite;
    if (!BusReadWrite)
      s_q <= smem[BusAddress[7:0]];
    if (BusReadWrite && BusAddress[15:8] == 8'h00)
      smem[BusAddress[7:0]] <= BusData;
    if (BusReadWrite && BusAddress != 16'hFFFF && wn < 64) begin
      wl_a[wn] <= BusAddress;
      wl_d[wn] <= BusData;
      wl_c[wn] <= cyc;
      wn <= wn + 1;
    end
  end

  task automatic tick();
    @(posedge BusClock);
    #1;
  endtask

  task automatic push(input logic w, input logic [15:0] a,
                      input logic [7:0] d);
    CmdValid = 1'b1;
    CmdWrite = w;
    CmdAddr  = a;
    CmdData  = d;
    tick();
    CmdValid = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    // Reset and idle
    Reset = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
    chk("rst_addr", 32'(BusAddress), 32'hFFFF);
    chk("rst_rw", 32'(BusReadWrite), 32'd1);
    chk("rst_data", 32'(BusData), 32'h00);
    chk("rst_rspv", 32'(RspValid), 32'd0);
    chk("rst_rspd", 32'(RspData), 32'h00);
    chk("rst_rdy", 32'(CmdReady), 32'd1);
    chk("rst_busy", 32'(Busy), 32'd0);

    // Single write
    push(1'b1, 16'h0041, 8'h20);
    chk("w1_busy", 32'(Busy), 32'd1);
    chk("w1_park", 32'(BusAddress), 32'hFFFF);
    tick();
    chk("w1_addr", 32'(BusAddress), 32'h0041);
    chk("w1_rw", 32'(BusReadWrite), 32'd1);
    chk("w1_data", 32'(BusData), 32'h20);
    tick();
    chk("w1_gap_a", 32'(BusAddress), 32'hFFFF);
    chk("w1_gap_d", 32'(BusData), 32'h00);
    chk("w1_gap_busy", 32'(Busy), 32'd1);
    tick();
    chk("w1_idle_busy", 32'(Busy), 32'd0);

    // Write then read back with RspReady low
    push(1'b1, 16'h0043, 8'h80);
    push(1'b0, 16'h0043, 8'h55);
    chk("r1_wr_addr", 32'(BusAddress), 32'h0043);
    chk("r1_wr_data", 32'(BusData), 32'h80);
    tick();
    tick();
    tick();
    chk("r1_ra_addr", 32'(BusAddress), 32'h0043);
    chk("r1_ra_rw", 32'(BusReadWrite), 32'd0);
    tick();
    chk("r1_rc_rw", 32'(BusReadWrite), 32'd0);
    chk("r1_rc_data", 32'(BusData), 32'h80);
    chk("r1_rc_rspv", 32'(RspValid), 32'd0);
    tick();
    chk("r1_gap_addr", 32'(BusAddress), 32'hFFFF);
    chk("r1_rspv", 32'(RspValid), 32'd1);
    chk("r1_rspd", 32'(RspData), 32'h80);
    tick();
    chk("r1_hold", 32'(RspValid), 32'd1);
    RspReady = 1'b1;
    tick();
    RspReady = 1'b0;
    chk("r1_consumed", 32'(RspValid), 32'd0);

    // Back-pressure: six back-to-back writes
    base = wn;
    for (int i = 0; i < 6; i++) begin
      push(1'b1, 16'h0010 + 16'(i), 8'hA0 + 8'(i));
      chk($sformatf("bp_rdy%0d", i), 32'(CmdReady), (i == 5) ? 32'd0 : 32'd1);
    end
    tick();
    chk("bp_full", 32'(CmdReady), 32'd0);
    tick();
    chk("bp_reopen", 32'(CmdReady), 32'd1);
    repeat (12) tick();
    chk("bp_busy", 32'(Busy), 32'd0);
    chk("bp_count", 32'(wn - base), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("bp_a%0d", i), 32'(wl_a[base+i]), 32'h0010 + i);
      chk($sformatf("bp_d%0d", i), 32'(wl_d[base+i]), 32'h00A0 + i);
      if (i > 0)
        chk($sformatf("bp_gap%0d", i),
            32'(wl_c[base+i] - wl_c[base+i-1]), 32'd3);
    end

    // Response stall
    push(1'b0, 16'h0041, 8'h00);
    push(1'b0, 16'h0010, 8'h00);
    chk("rs_ra1", 32'(BusAddress), 32'h0041);
    tick();
    tick();
    chk("rs_rspv1", 32'(RspValid), 32'd1);
    chk("rs_rspd1", 32'(RspData), 32'h20);
    tick();
    tick();
    chk("rs_park_a", 32'(BusAddress), 32'hFFFF);
    chk("rs_park_rw", 32'(BusReadWrite), 32'd1);
    chk("rs_busy", 32'(Busy), 32'd1);
    tick();
    chk("rs_still", 32'(BusAddress), 32'hFFFF);
    chk("rs_keep", 32'(RspData), 32'h20);
    RspReady = 1'b1;
    tick();
    RspReady = 1'b0;
    chk("rs_ra2", 32'(BusAddress), 32'h0010);
    chk("rs_ra2_rw", 32'(BusReadWrite), 32'd0);
    chk("rs_clr", 32'(RspValid), 32'd0);
    tick();
    chk("rs_rc2_d", 32'(BusData), 32'hA0);
    tick();
    chk("rs_rspv2", 32'(RspValid), 32'd1);
    chk("rs_rspd2", 32'(RspData), 32'hA0);

    // Reset during RD_CAP, with a write queued behind the read
    RspReady = 1'b1;
    push(1'b0, 16'h0043, 8'h00);
    RspReady = 1'b0;
    push(1'b1, 16'h0012, 8'h77);
    chk("mr_ra", 32'(BusAddress), 32'h0043);
    tick();
    chk("mr_rc_rw", 32'(BusReadWrite), 32'd0);
    wn_snap = wn;
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    chk("mr_rspv", 32'(RspValid), 32'd0);
    chk("mr_addr", 32'(BusAddress), 32'hFFFF);
    chk("mr_rw", 32'(BusReadWrite), 32'd1);
    chk("mr_data", 32'(BusData), 32'h00);
    chk("mr_busy", 32'(Busy), 32'd0);
    repeat (4) tick();
    chk("mr_nowr", 32'(wn - wn_snap), 32'd0);
    chk("mr_rspv2", 32'(RspValid), 32'd0);
    chk("mr_rdy", 32'(CmdReady), 32'd1);
    chk("mr_busy2", 32'(Busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
